// File: rtl/multi_scaler.sv
// Multi-channel pulse scaler: per-channel edge counters with a period
// snapshot taken on every endcount strobe, plus a one-cycle-latency readout
// port for the snapshot bank.
module multi_scaler #(
    parameter int NCH    = 16,
    parameter int DATA_W = 32,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    din,
    input  logic [1:0]        edge_sel,
    input  logic              enable,
    input  logic              endcount,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_ovf,
    output logic              rd_err,
    output logic              snap_valid,
    output logic [15:0]       period_cnt
);

    localparam logic [DATA_W-1:0] CNT_MAX = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] CNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]       NCH_LIM = (AW+1)'(NCH);

    // Saturating increment: a full counter stays at all-ones.
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic [NCH-1:0]    sync1_r;
    logic [NCH-1:0]    sync2_r;
    logic [NCH-1:0]    prev_r;
    logic [NCH-1:0]    pulse_r;
    logic [NCH-1:0]    rise_s;
    logic [NCH-1:0]    fall_s;
    logic [NCH-1:0]    edge_s;
    logic [NCH-1:0]    gated_s;
    logic [DATA_W-1:0] cnt_r      [NCH];
    logic [DATA_W-1:0] snap_r     [NCH];
    logic [NCH-1:0]    ovf_r;
    logic [NCH-1:0]    snap_ovf_r;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_ovf_s;
    logic              addr_ok_s;

    // Two-flop synchroniser, previous-sample flop and registered edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= '0;
            pulse_r <= '0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            pulse_r <= edge_s;
        end
    end

    // Edge selection; the 11 code behaves like falling-edge mode.
    always_comb begin
        rise_s = sync2_r & ~prev_r;
        fall_s = ~sync2_r & prev_r;
        edge_s = '0;
        case (edge_sel)
            2'b01:   edge_s = rise_s;
            2'b10:   edge_s = rise_s | fall_s;
            default: edge_s = fall_s;
        endcase
    end

    assign gated_s = pulse_r & {NCH{enable}};

    // Per-channel counters, sticky overflow and snapshot capture at endcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i]  <= '0;
                snap_r[i] <= '0;
            end
            ovf_r      <= '0;
            snap_ovf_r <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (endcount) begin
                    // A pulse landing on the boundary belongs to the new period.
                    snap_r[i]     <= cnt_r[i];
                    snap_ovf_r[i] <= ovf_r[i];
                    cnt_r[i]      <= gated_s[i] ? CNT_ONE : '0;
                    ovf_r[i]      <= 1'b0;
                end else if (gated_s[i]) begin
                    cnt_r[i] <= sat_inc(cnt_r[i]);
                    ovf_r[i] <= ovf_r[i] | (sat_inc(cnt_r[i]) == CNT_MAX);
                end
            end
        end
    end

    // Snapshot readout multiplexer with address range check.
    always_comb begin
        sel_data_s = '0;
        sel_ovf_s  = 1'b0;
        addr_ok_s  = ({1'b0, rd_addr} < NCH_LIM);
        for (int i = 0; i < NCH; i++) begin
            sel_data_s = sel_data_s | (snap_r[i] & {DATA_W{({1'b0, rd_addr} == (AW+1)'(i))}});
            sel_ovf_s  = sel_ovf_s | (snap_ovf_r[i] & ({1'b0, rd_addr} == (AW+1)'(i)));
        end
    end

    // Readout register: captures the pre-update snapshot, holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_ovf   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= addr_ok_s ? sel_data_s : '0;
                rd_ovf  <= addr_ok_s & sel_ovf_s;
                rd_err  <= ~addr_ok_s;
            end
        end
    end

    // Period bookkeeping: snapshot-ready pulse and wrapping period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_valid <= 1'b0;
            period_cnt <= 16'd0;
        end else begin
            snap_valid <= endcount;
            if (endcount) begin
                period_cnt <= period_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_multi_scaler.sv
// Self-checking bench for multi_scaler: directed corner sequences, a table of
// edge-mode vectors and a randomized run checked against a behavioural model.
module tb_multi_scaler;

    localparam int NCH    = 16;
    localparam int DATA_W = 8;
    localparam int AW     = 6;
    localparam int MAXV   = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NCH-1:0]    din_v = '0;
    logic [1:0]        edge_sel_v = 2'b00;
    logic              enable_v = 1'b0;
    logic              endcount_v = 1'b0;
    logic              rd_en_v = 1'b0;
    logic [AW-1:0]     rd_addr_v = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ovf;
    logic              rd_err;
    logic              snap_valid;
    logic [15:0]       period_cnt;

    multi_scaler #(.NCH(NCH), .DATA_W(DATA_W), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din_v),
        .edge_sel   (edge_sel_v),
        .enable     (enable_v),
        .endcount   (endcount_v),
        .rd_en      (rd_en_v),
        .rd_addr    (rd_addr_v),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ovf     (rd_ovf),
        .rd_err     (rd_err),
        .snap_valid (snap_valid),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model state: counts per channel, snapshots, input history.
    int             m_cnt  [NCH];
    int             m_snap [NCH];
    bit             m_snap_ovf [NCH];
    int             m_period;
    logic [NCH-1:0] din_h [5];
    logic [1:0]     sel_h [2];
    bit             e_rd_valid;
    int             e_rd_data;
    bit             e_rd_ovf;
    bit             e_rd_err;
    bit             e_snap_valid;

    typedef struct {
        logic [1:0] sel;
        logic       en;
        int         exp;
        string      name;
    } mode_vec_t;
    mode_vec_t mode_tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0;
            m_snap[c] = 0;
            m_snap_ovf[c] = 1'b0;
        end
        for (int k = 0; k < 5; k++) din_h[k] = '0;
        sel_h[0] = 2'b00;
        sel_h[1] = 2'b00;
        m_period = 0;
        e_rd_valid = 1'b0;
        e_rd_data = 0;
        e_rd_ovf = 1'b0;
        e_rd_err = 1'b0;
        e_snap_valid = 1'b0;
    endfunction

    // One rising edge of the model: a din change applied before edge t-3 is
    // counted at edge t, compared with the edge_sel that was applied at t-1.
    function automatic void model_edge();
        bit a, b, ev, g;
        for (int k = 4; k > 0; k--) din_h[k] = din_h[k-1];
        din_h[0] = din_v;
        sel_h[1] = sel_h[0];
        sel_h[0] = edge_sel_v;
        e_rd_valid = rd_en_v;
        if (rd_en_v) begin
            if (int'(rd_addr_v) < NCH) begin
                e_rd_data = m_snap[rd_addr_v];
                e_rd_ovf  = m_snap_ovf[rd_addr_v];
                e_rd_err  = 1'b0;
            end else begin
                e_rd_data = 0;
                e_rd_ovf  = 1'b0;
                e_rd_err  = 1'b1;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            a = din_h[3][c];
            b = din_h[4][c];
            case (sel_h[1])
                2'b01:   ev = a && !b;
                2'b10:   ev = (a != b);
                default: ev = !a && b;
            endcase
            g = ev && enable_v;
            if (endcount_v) begin
                m_snap[c] = m_cnt[c];
                m_snap_ovf[c] = (m_cnt[c] == MAXV);
                m_cnt[c] = g ? 1 : 0;
            end else if (g && m_cnt[c] < MAXV) begin
                m_cnt[c] = m_cnt[c] + 1;
            end
        end
        if (endcount_v) m_period = (m_period + 1) % 65536;
        e_snap_valid = endcount_v;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic tog(input logic [NCH-1:0] m, input int hold);
        din_v = din_v ^ m;
        repeat (hold) step();
    endtask

    task automatic endc();
        endcount_v = 1'b1;
        step();
        endcount_v = 1'b0;
    endtask

    task automatic read_chk(input int addr, input int exp_d, input bit exp_o,
                            input bit exp_e, input string nm);
        rd_en_v = 1'b1;
        rd_addr_v = AW'(addr);
        step();
        rd_en_v = 1'b0;
        chk({nm, "_valid"}, rd_valid, 1);
        chk({nm, "_data"}, rd_data, exp_d);
        chk({nm, "_ovf"}, rd_ovf, exp_o);
        chk({nm, "_err"}, rd_err, exp_e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din_v = '0;
        edge_sel_v = 2'b00;
        enable_v = 1'b0;
        endcount_v = 1'b0;
        rd_en_v = 1'b0;
        rd_addr_v = '0;
        #1;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_ovf", rd_ovf, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_snap_valid", snap_valid, 0);
        chk("rst_period_cnt", period_cnt, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("mon_snap_valid", snap_valid, e_snap_valid);
            chk("mon_rd_valid", rd_valid, e_rd_valid);
            chk("mon_period_cnt", period_cnt, m_period);
            if (e_rd_valid) begin
                chk("mon_rd_data", rd_data, e_rd_data);
                chk("mon_rd_ovf", rd_ovf, e_rd_ovf);
                chk("mon_rd_err", rd_err, e_rd_err);
            end
        end
    end

    initial begin
        mode_tbl[0] = '{2'b01, 1'b1, 1, "mode_rise"};
        mode_tbl[1] = '{2'b10, 1'b1, 2, "mode_both"};
        mode_tbl[2] = '{2'b11, 1'b1, 1, "mode_11"};
        mode_tbl[3] = '{2'b00, 1'b1, 1, "mode_fall"};
        mode_tbl[4] = '{2'b01, 1'b0, 0, "mode_rise_dis"};
        mode_tbl[5] = '{2'b10, 1'b0, 0, "mode_both_dis"};

        #3;
        do_reset();
        mon_en = 1'b1;

        // Falling-edge count on ch0 (5) and ch3 (3).
        edge_sel_v = 2'b00;
        enable_v = 1'b1;
        endc();
        for (int i = 0; i < 5; i++) begin
            tog((i < 3) ? 16'h0009 : 16'h0001, 2);
            tog((i < 3) ? 16'h0009 : 16'h0001, 2);
        end
        idle(5);
        chk("sv_before", snap_valid, 0);
        endc();
        chk("sv_pulse", snap_valid, 1);
        step();
        chk("sv_after", snap_valid, 0);
        read_chk(0, 5, 1'b0, 1'b0, "fall_ch0");
        read_chk(3, 3, 1'b0, 1'b0, "fall_ch3");

        // Pulse coincident with endcount goes to the new period.
        din_v[5] = 1'b1;
        idle(5);
        endc();
        din_v[5] = 1'b0;
        step();
        step();
        step();
        endc();
        idle(5);
        read_chk(5, 0, 1'b0, 1'b0, "coinc_old");
        endc();
        read_chk(5, 1, 1'b0, 1'b0, "coinc_new");

        // Saturation on ch1, then a clean period.
        edge_sel_v = 2'b10;
        idle(2);
        endc();
        for (int i = 0; i < 300; i++) tog(16'h0002, 2);
        idle(5);
        endc();
        read_chk(1, 255, 1'b1, 1'b0, "sat");
        tog(16'h0002, 2);
        tog(16'h0002, 2);
        idle(5);
        endc();
        read_chk(1, 2, 1'b0, 1'b0, "sat_next");

        // Edge-mode table on ch2: one full high pulse per entry.
        for (int t = 0; t < 6; t++) begin
            edge_sel_v = mode_tbl[t].sel;
            enable_v = mode_tbl[t].en;
            idle(5);
            endc();
            din_v[2] = 1'b1;
            idle(3);
            din_v[2] = 1'b0;
            idle(3);
            idle(5);
            endc();
            read_chk(2, mode_tbl[t].exp, 1'b0, 1'b0, mode_tbl[t].name);
        end

        // Readout corners.
        enable_v = 1'b1;
        edge_sel_v = 2'b10;
        read_chk(NCH, 0, 1'b0, 1'b1, "addr_nch");
        read_chk(63, 0, 1'b0, 1'b1, "addr_max");
        endc();
        for (int i = 0; i < 3; i++) tog(16'h0010, 2);
        idle(5);
        endc();
        tog(16'h0010, 2);
        idle(5);
        rd_en_v = 1'b1;
        rd_addr_v = 6'd4;
        endcount_v = 1'b1;
        step();
        endcount_v = 1'b0;
        chk("rd_on_endc_data", rd_data, 3);
        step();
        rd_en_v = 1'b0;
        chk("rd_after_endc_data", rd_data, 1);
        rd_en_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr_v = AW'(i);
            step();
            chk("b2b_valid", rd_valid, 1);
        end
        rd_en_v = 1'b0;
        step();
        chk("b2b_idle_valid", rd_valid, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 5) == 0) din_v[ch] = ~din_v[ch];
            end
            if ($urandom_range(0, 99) == 0) edge_sel_v = 2'($urandom_range(0, 3));
            enable_v = ($urandom_range(0, 9) != 0);
            endcount_v = ($urandom_range(0, 39) == 0);
            rd_en_v = ($urandom_range(0, 2) == 0);
            rd_addr_v = AW'($urandom_range(0, 20));
            step();
        end
        endcount_v = 1'b0;
        rd_en_v = 1'b0;
        idle(5);

        // Reset mid-period discards a partial count of 7.
        edge_sel_v = 2'b01;
        enable_v = 1'b1;
        din_v = '0;
        idle(5);
        endc();
        for (int i = 0; i < 7; i++) begin
            tog(16'h0040, 2);
            tog(16'h0040, 2);
        end
        idle(5);
        do_reset();
        edge_sel_v = 2'b01;
        enable_v = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tog(16'h0040, 2);
            tog(16'h0040, 2);
        end
        idle(5);
        endc();
        read_chk(6, 2, 1'b0, 1'b0, "post_reset");

        // Period counter wrap.
        do_reset();
        endcount_v = 1'b1;
        repeat (65535) step();
        chk("period_ffff", period_cnt, 16'hFFFF);
        step();
        chk("period_wrap", period_cnt, 0);
        endcount_v = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
